pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage 64-bit pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers by detecting load-use hazards and taken-branch flushes. It also runs a req/ack handshake with a variable-latency data memory, freezing the pipeline and inserting bubbles into MEM/WB until the access completes. It is instantiated next to the pipeline registers in the core top level.

---
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central stall/flush controller for the 5-stage 64-bit pipeline.
//            Detects load-use hazards and taken-branch flushes, and runs a
//            req/ack handshake with a variable-latency data memory. While the
//            access is outstanding it freezes the pipeline and bubbles MEM/WB.
// Ports    : clk, reset (async, active-low)
//            id_rs1/id_rs2/ex_rd/ex_memread/ex_branch_taken - hazard inputs
//            mem_memread/mem_memwrite/dmem_ack             - memory handshake
//            dmem_req                                      - request (Moore)
//            stall_pc/stall_ifid/stall_idex/stall_exmem     - register holds
//            bubble_idex/flush_ifid/bubble_memwb            - bubble/flush
//            mem_timeout                                    - sticky fatal flag
//            stall_cycles                                   - saturating count
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic        bubble_memwb,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [31:0]      C_SAT     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_dmem_req;
  logic             r_mem_timeout;
  logic [31:0]      r_stall_cycles;

  logic             w_access;
  logic             w_freeze;
  logic             w_load_use;
  logic             w_stall_front;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_access   = mem_memread | mem_memwrite;
  // The detection cycle in IDLE is already frozen so the MEM instruction
  // stays put while the request is raised on the following cycle.
  assign w_freeze   = ((r_state == ST_IDLE) && w_access) ||
                      ((r_state == ST_WAIT) && !dmem_ack) ||
                      (r_state == ST_ERROR);
  assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  // A taken branch discards the ID instruction, so it overrides load-use.
  assign w_stall_front = w_freeze || (!ex_branch_taken && w_load_use);
  assign w_cnt_next    = r_wait_cnt + CNT_W'(1);

  assign stall_pc     = w_stall_front;
  assign stall_ifid   = w_stall_front;
  assign stall_idex   = w_freeze;
  assign stall_exmem  = w_freeze;
  assign bubble_idex  = !w_freeze && (ex_branch_taken || w_load_use);
  assign flush_ifid   = !w_freeze && ex_branch_taken;
  assign bubble_memwb = w_freeze;

  assign dmem_req     = r_dmem_req;
  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_wait_cnt     <= '0;
      r_dmem_req     <= 1'b0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_stall_front && (r_stall_cycles != C_SAT)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_state    <= ST_WAIT;
            r_dmem_req <= 1'b1;
            r_wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            r_state    <= ST_IDLE;
            r_dmem_req <= 1'b0;
          end else if (w_cnt_next == C_TIMEOUT) begin
            // Counter stops at TIMEOUT_CYCLES; ERROR is terminal so it
            // can never wrap.
            r_state       <= ST_ERROR;
            r_dmem_req    <= 1'b0;
            r_mem_timeout <= 1'b1;
            r_wait_cnt    <= w_cnt_next;
          end else begin
            r_wait_cnt <= w_cnt_next;
          end
        end
        ST_ERROR: begin
          r_state    <= ST_ERROR;
          r_dmem_req <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl. Directed scenarios
//            followed by randomized stimulus, all compared against a
//            behavioural model of the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_memread, ex_branch_taken, mem_memread, mem_memwrite, dmem_ack;
  logic        dmem_req, stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        bubble_idex, flush_ifid, bubble_memwb, mem_timeout;
  logic [31:0] stall_cycles;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .stall_idex(stall_idex), .stall_exmem(stall_exmem),
    .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .bubble_memwb(bubble_memwb), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: memory phase (0 idle, 1 waiting for ack, 2 dead), cycles waited,
  // sticky timeout and the stall counter.
  int          m_phase;
  int          m_waited;
  bit          m_to;
  logic [31:0] m_sc;

  logic [6:0] obs_ctl;
  assign obs_ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem,
                    bubble_idex, flush_ifid, bubble_memwb};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_frozen();
    bit acc = mem_memread | mem_memwrite;
    return (m_phase == 0 && acc) || (m_phase == 1 && !dmem_ack) || (m_phase == 2);
  endfunction

  function automatic logic [6:0] exp_ctl();
    bit frz = model_frozen();
    bit lu  = ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    bit stf = frz || (!ex_branch_taken && lu);
    bit bid = !frz && (ex_branch_taken || lu);
    bit fl  = !frz && ex_branch_taken;
    return {stf, stf, frz, frz, bid, fl, frz};
  endfunction

  task automatic model_clear();
    m_phase = 0; m_waited = 0; m_to = 0; m_sc = 32'd0;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".ctl"}, {25'd0, obs_ctl}, {25'd0, exp_ctl()});
    check_val({tag, ".req"}, {31'd0, dmem_req}, {31'd0, (m_phase == 1)});
    check_val({tag, ".to"},  {31'd0, mem_timeout}, {31'd0, m_to});
    check_val({tag, ".sc"},  stall_cycles, m_sc);
  endtask

  task automatic set_in(input int rs1, input int rs2, input int rd, input bit lmr,
                        input bit br, input bit mr, input bit mw, input bit ack);
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); ex_rd = 5'(rd); ex_memread = lmr;
    ex_branch_taken = br; mem_memread = mr; mem_memwrite = mw; dmem_ack = ack;
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic step(input string tag);
    bit stf;
    #1 check_all(tag);
    stf = exp_ctl()[6];
    @(posedge clk);
    if (stf && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    case (m_phase)
      0: if (mem_memread | mem_memwrite) begin m_phase = 1; m_waited = 0; end
      1: if (dmem_ack) m_phase = 0;
         else begin
           m_waited++;
           if (m_waited == T) begin m_phase = 2; m_to = 1; end
         end
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    #1 check_all("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] sc0;

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #2 check_all("por");
    @(negedge clk);
    reset = 1'b1;

    // Load-use: one stall cycle, counter steps by one.
    set_in(0, 5, 5, 1, 0, 0, 0, 0);
    step("lu");
    check_val("lu_cnt", stall_cycles, 32'd1);
    // Load to x0 is never a hazard.
    set_in(0, 0, 0, 1, 0, 0, 0, 0);
    #1 check_val("lu_x0", {25'd0, obs_ctl}, 32'd0);
    step("lu_x0");
    // Taken branch overrides the load-use stall.
    set_in(0, 5, 5, 1, 1, 0, 0, 0);
    #1 check_val("br_lu", {25'd0, obs_ctl}, 32'b0000110);
    step("br_lu");

    // Handshake: read detected in cycle 0, ack in cycle 3.
    sc0 = stall_cycles;
    set_in(1, 2, 3, 0, 0, 1, 0, 0);
    step("hs0"); step("hs1"); step("hs2");
    dmem_ack = 1'b1;
    #1 check_val("hs3_rel", {25'd0, obs_ctl}, 32'd0);
    step("hs3");
    set_in(1, 2, 3, 0, 0, 0, 0, 0);
    step("hs4");
    check_val("hs_stalls", stall_cycles - sc0, 32'd3);

    // Timeout: write never acked.
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < T + 1; i++) step("to_wait");
    check_val("to_flag", {31'd0, mem_timeout}, 32'd1);
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) step("to_err_ack");
    do_reset();

    // Asynchronous reset in the middle of a WAIT.
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    step("ar_det"); step("ar_wait");
    #2 reset = 1'b0;
    #1;
    check_val("ar_req", {31'd0, dmem_req}, 32'd0);
    check_val("ar_to", {31'd0, mem_timeout}, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    mem_memread = 1'b0;
    #1 check_val("ar_post", {25'd0, obs_ctl}, 32'd0);
    step("ar_post");

    // Saturation: preload the counter just below the ceiling.
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1 release dut.r_stall_cycles;
    m_sc = 32'hFFFF_FFFD;
    set_in(7, 0, 7, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("sat");
    check_val("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        bit acc = (m_phase == 1) ? 1'b1 : ($urandom_range(0, 99) < 20);
        bit rw  = $urandom_range(0, 1);
        set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
               acc && rw, acc && !rw, ($urandom_range(0, 99) < 35));
        step("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
